// File: rtl/paddle_ctl_pkg.sv
// Shared types and widths for the paddle controller.
package paddle_ctl_pkg;

    localparam int STEP_W = 4;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        CENTER = 2'd0,
        WAIT   = 2'd1,
        PLAY   = 2'd2,
        FREEZE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } dir_t;

    // Both buttons pressed cancels out rather than favouring one direction.
    function automatic dir_t resolve_dir(input logic up, input logic dn);
        if (up && !dn) return UP;
        if (dn && !up) return DN;
        return NONE;
    endfunction

endpackage

// File: rtl/paddle_ctl_btn_debounce.sv
// Button conditioning: two-flop synchroniser, then a level filter that only
// looks at the synchronised input once per video frame.
module btn_debounce #(
    parameter int unsigned DEB_FRAMES = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic frame_tick,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    logic [1:0] sync_q;
    logic [3:0] cnt;

    // Synchronise, then count consecutive frame samples that disagree with
    // the accepted level; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            rise   <= 1'b0;
            if (frame_tick) begin
                if (sync_q[1] == level) begin
                    cnt <= '0;
                end else if (cnt == 4'(DEB_FRAMES - 1)) begin
                    cnt   <= '0;
                    level <= sync_q[1];
                    rise  <= sync_q[1];
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/paddle_ctl.sv
// Round sequencing and paddle move strobes for a two-player paddle game.
//
//   state  | meaning
//   CENTER | one cycle, center pulse recentres both paddles
//   WAIT   | idle until a start press
//   PLAY   | paddles move on each frame; start pauses, point freezes
//   FREEZE | hold for FREEZE_FRAMES frames after a point, then recentre
module paddle_ctl
    import paddle_ctl_pkg::*;
#(
    parameter int unsigned DEB_FRAMES    = 3,
    parameter int unsigned ACCEL_FRAMES  = 8,
    parameter int unsigned MAX_STEP      = 4,
    parameter int unsigned FREEZE_FRAMES = 60
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              frame_tick,
    input  logic              btn_p1_up,
    input  logic              btn_p1_dn,
    input  logic              btn_p2_up,
    input  logic              btn_p2_dn,
    input  logic              btn_start,
    input  logic              point,
    output logic              p1_up,
    output logic              p1_dn,
    output logic              p2_up,
    output logic              p2_dn,
    output logic [STEP_W-1:0] p1_step,
    output logic [STEP_W-1:0] p2_step,
    output logic              center,
    output logic              playing,
    output logic [1:0]        state
);

    state_t            st;
    logic [7:0]        frz_cnt;
    logic [3:0]        dir_raw;
    logic [3:0]        dir_lvl;
    logic [3:0]        dir_rise_unused;
    logic              start_lvl_unused;
    logic              start_edge;

    logic [HOLD_W-1:0] hold     [2];
    logic [HOLD_W-1:0] hold_nx  [2];
    dir_t              prev_dir [2];
    dir_t              dir_now  [2];
    logic [STEP_W-1:0] step_q   [2];
    logic              up_q     [2];
    logic              dn_q     [2];

    // Bit order: p1 up, p1 dn, p2 up, p2 dn.
    assign dir_raw = {btn_p2_dn, btn_p2_up, btn_p1_dn, btn_p1_up};

    for (genvar i = 0; i < 4; i++) begin : g_dir_deb
        btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb (
            .clk        (clk),
            .rstn       (rstn),
            .frame_tick (frame_tick),
            .btn_raw    (dir_raw[i]),
            .level      (dir_lvl[i]),
            .rise       (dir_rise_unused[i])
        );
    end

    btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_start (
        .clk        (clk),
        .rstn       (rstn),
        .frame_tick (frame_tick),
        .btn_raw    (btn_start),
        .level      (start_lvl_unused),
        .rise       (start_edge)
    );

    function automatic logic [STEP_W-1:0] step_of(input logic [HOLD_W-1:0] h);
        int q;
        q = 1 + int'(h) / int'(ACCEL_FRAMES);
        if (q > int'(MAX_STEP)) q = int'(MAX_STEP);
        return STEP_W'(q);
    endfunction

    // Resolve direction and the hold count this frame would produce.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            dir_now[p] = resolve_dir(dir_lvl[2*p], dir_lvl[2*p+1]);
            hold_nx[p] = '0;
            if (dir_now[p] != NONE && dir_now[p] == prev_dir[p])
                hold_nx[p] = (hold[p] == '1) ? hold[p] : hold[p] + 1'b1;
        end
    end

    // Round state machine; center is high exactly while sitting in CENTER,
    // so the post-reset CENTER cycle waits for its own pulse before leaving.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            st      <= CENTER;
            center  <= 1'b0;
            playing <= 1'b0;
            frz_cnt <= '0;
        end else begin
            case (st)
                CENTER: begin
                    if (center) begin
                        center <= 1'b0;
                        st     <= WAIT;
                    end else begin
                        center <= 1'b1;
                    end
                end
                WAIT: begin
                    if (start_edge) begin
                        st      <= PLAY;
                        playing <= 1'b1;
                    end
                end
                PLAY: begin
                    if (point) begin
                        st      <= FREEZE;
                        playing <= 1'b0;
                        frz_cnt <= 8'(FREEZE_FRAMES);
                    end else if (start_edge) begin
                        st      <= WAIT;
                        playing <= 1'b0;
                    end
                end
                FREEZE: begin
                    if (frame_tick) begin
                        if (frz_cnt <= 8'd1) begin
                            frz_cnt <= '0;
                            st      <= CENTER;
                            center  <= 1'b1;
                        end else begin
                            frz_cnt <= frz_cnt - 8'd1;
                        end
                    end
                end
                default: st <= CENTER;
            endcase
        end
    end

    // Per-player move strobes; anything that takes us out of PLAY wipes the
    // acceleration history so the next rally starts at step 1.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int p = 0; p < 2; p++) begin
                hold[p]     <= '0;
                prev_dir[p] <= NONE;
                step_q[p]   <= STEP_W'(1);
                up_q[p]     <= 1'b0;
                dn_q[p]     <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                up_q[p] <= 1'b0;
                dn_q[p] <= 1'b0;
                if (st != PLAY || point || start_edge) begin
                    hold[p]     <= '0;
                    prev_dir[p] <= NONE;
                end else if (frame_tick) begin
                    hold[p]     <= hold_nx[p];
                    prev_dir[p] <= dir_now[p];
                    if (dir_now[p] != NONE) begin
                        step_q[p] <= step_of(hold_nx[p]);
                        up_q[p]   <= (dir_now[p] == UP);
                        dn_q[p]   <= (dir_now[p] == DN);
                    end
                end
            end
        end
    end

    assign p1_up   = up_q[0];
    assign p1_dn   = dn_q[0];
    assign p2_up   = up_q[1];
    assign p2_dn   = dn_q[1];
    assign p1_step = step_q[0];
    assign p2_step = step_q[1];
    assign state   = st;

endmodule

// File: tb/tb_paddle_ctl.sv
// Bench for paddle_ctl: frame-level reference model plus directed and random frames.
module tb_paddle_ctl;

    localparam int DEB_FRAMES    = 3;
    localparam int ACCEL_FRAMES  = 8;
    localparam int MAX_STEP      = 4;
    localparam int FREEZE_FRAMES = 60;

    localparam int S_CENTER = 0;
    localparam int S_WAIT   = 1;
    localparam int S_PLAY   = 2;
    localparam int S_FREEZE = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_p1_up = 1'b0, btn_p1_dn = 1'b0, btn_p2_up = 1'b0, btn_p2_dn = 1'b0;
    logic       btn_start = 1'b0;
    logic       point = 1'b0;
    logic       p1_up, p1_dn, p2_up, p2_dn;
    logic [3:0] p1_step, p2_step;
    logic       center, playing;
    logic [1:0] state;

    paddle_ctl #(
        .DEB_FRAMES    (DEB_FRAMES),
        .ACCEL_FRAMES  (ACCEL_FRAMES),
        .MAX_STEP      (MAX_STEP),
        .FREEZE_FRAMES (FREEZE_FRAMES)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .frame_tick (frame_tick),
        .btn_p1_up  (btn_p1_up),
        .btn_p1_dn  (btn_p1_dn),
        .btn_p2_up  (btn_p2_up),
        .btn_p2_dn  (btn_p2_dn),
        .btn_start  (btn_start),
        .point      (point),
        .p1_up      (p1_up),
        .p1_dn      (p1_dn),
        .p2_up      (p2_up),
        .p2_dn      (p2_dn),
        .p1_step    (p1_step),
        .p2_step    (p2_step),
        .center     (center),
        .playing    (playing),
        .state      (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model, advanced once per frame.
    int         m_state;
    int         m_frz;
    logic [4:0] m_lvl;
    logic [4:0] run_val;
    int         run_len [5];
    logic [4:0] last_btns;
    int         m_hold [2];
    int         m_prev [2];
    int         m_step [2];

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int strobes();
        return int'({p2_dn, p2_up, p1_dn, p1_up});
    endfunction

    task automatic set_btns(input logic [4:0] b);
        btn_p1_up = b[0];
        btn_p1_dn = b[1];
        btn_p2_up = b[2];
        btn_p2_dn = b[3];
        btn_start = b[4];
    endtask

    task automatic clear_holds();
        for (int p = 0; p < 2; p++) begin
            m_hold[p] = 0;
            m_prev[p] = 0;
        end
    endtask

    // Entered and left at a negedge.
    task automatic do_reset();
        frame_tick = 1'b0;
        point      = 1'b0;
        rstn       = 1'b0;
        set_btns(5'b0);
        repeat (3) @(negedge clk);
        check_val("rst_state", int'(state), S_CENTER);
        check_val("rst_center", int'(center), 0);
        check_val("rst_playing", int'(playing), 0);
        check_val("rst_strb", strobes(), 0);
        check_val("rst_p1_step", int'(p1_step), 1);
        check_val("rst_p2_step", int'(p2_step), 1);
        rstn = 1'b1;
        @(negedge clk);
        check_val("post_rst_center", int'(center), 1);
        check_val("post_rst_state", int'(state), S_CENTER);
        @(negedge clk);
        check_val("post_rst_center_off", int'(center), 0);
        check_val("post_rst_wait", int'(state), S_WAIT);
        m_state   = S_WAIT;
        m_frz     = 0;
        m_lvl     = '0;
        run_val   = '0;
        last_btns = '0;
        for (int i = 0; i < 5; i++) run_len[i] = 0;
        clear_holds();
        m_step[0] = 1;
        m_step[1] = 1;
    endtask

    // One frame: tick (optionally with point), then four quiet cycles.
    task automatic run_frame(input logic [4:0] btns, input logic pt);
        logic [3:0] exp_strb;
        logic [4:0] s;
        int         exp_ctr, exp_n1, d, extra, cen;
        logic       up, dn, rose;

        exp_strb = '0;
        exp_ctr  = 0;
        if (m_state == S_PLAY && !pt) begin
            for (int p = 0; p < 2; p++) begin
                up = m_lvl[2*p];
                dn = m_lvl[2*p+1];
                d  = (up && !dn) ? 1 : ((dn && !up) ? 2 : 0);
                if (d != 0 && d == m_prev[p]) m_hold[p] = (m_hold[p] < 255) ? m_hold[p] + 1 : 255;
                else m_hold[p] = 0;
                m_prev[p] = d;
                if (d != 0) begin
                    m_step[p] = 1 + m_hold[p] / ACCEL_FRAMES;
                    if (m_step[p] > MAX_STEP) m_step[p] = MAX_STEP;
                    exp_strb[2*p + d - 1] = 1'b1;
                end
            end
        end
        if (m_state == S_PLAY && pt) begin
            m_state = S_FREEZE;
            m_frz   = FREEZE_FRAMES;
            clear_holds();
        end else if (m_state == S_FREEZE) begin
            m_frz--;
            if (m_frz == 0) begin
                m_state = S_CENTER;
                exp_ctr = 1;
            end
        end
        exp_n1 = m_state;

        // A level is accepted once DEB_FRAMES consecutive samples agree on a new value.
        s         = last_btns;
        last_btns = btns;
        rose      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (s[i] == run_val[i]) run_len[i]++;
            else begin
                run_val[i] = s[i];
                run_len[i] = 1;
            end
            if (run_len[i] >= DEB_FRAMES && m_lvl[i] != run_val[i]) begin
                m_lvl[i] = run_val[i];
                if (i == 4 && run_val[i]) rose = 1'b1;
            end
        end
        if (rose && m_state == S_WAIT) m_state = S_PLAY;
        else if (rose && m_state == S_PLAY) begin
            m_state = S_WAIT;
            clear_holds();
        end
        if (m_state == S_CENTER) m_state = S_WAIT;

        set_btns(btns);
        frame_tick = 1'b1;
        point      = pt;
        @(negedge clk);
        frame_tick = 1'b0;
        point      = 1'b0;
        check_val("strb", strobes(), int'(exp_strb));
        check_val("p1_step", int'(p1_step), m_step[0]);
        check_val("p2_step", int'(p2_step), m_step[1]);
        check_val("center", int'(center), exp_ctr);
        check_val("state_t1", int'(state), exp_n1);
        extra = 0;
        cen   = 0;
        repeat (4) begin
            @(negedge clk);
            extra |= strobes();
            cen   |= int'(center);
        end
        check_val("strb_width", extra, 0);
        check_val("center_width", cen, 0);
        check_val("state", int'(state), m_state);
        check_val("playing", int'(playing), int'(m_state == S_PLAY));
    endtask

    initial begin
        logic [4:0] rb;
        @(negedge clk);
        do_reset();

        // Idle in WAIT with a held paddle button: no movement.
        repeat (10) run_frame(5'b00001, 1'b0);

        // Start held three frames, then released.
        repeat (3) run_frame(5'b10000, 1'b0);
        repeat (2) run_frame(5'b00000, 1'b0);
        check_val("start_play", int'(state), S_PLAY);

        // Acceleration on p1 down.
        repeat (23) run_frame(5'b00010, 1'b0);

        // Conflicting p2 buttons, then p2 up alone.
        repeat (5) run_frame(5'b01100, 1'b0);
        repeat (4) run_frame(5'b00100, 1'b0);

        // Long p1 up hold reaches the step ceiling.
        repeat (40) run_frame(5'b00001, 1'b0);
        check_val("sat_step", int'(p1_step), MAX_STEP);

        // Point coincident with a frame tick, then the freeze and recentre.
        run_frame(5'b00001, 1'b1);
        repeat (62) run_frame(5'b00001, 1'b0);
        check_val("after_freeze", int'(state), S_WAIT);

        // Back to play, then a two-frame glitch.
        repeat (3) run_frame(5'b10000, 1'b0);
        repeat (2) run_frame(5'b00000, 1'b0);
        repeat (2) run_frame(5'b00001, 1'b0);
        repeat (5) run_frame(5'b00000, 1'b0);

        // Reset landing on a frame tick while p1 is moving.
        repeat (6) run_frame(5'b00001, 1'b0);
        frame_tick = 1'b1;
        rstn       = 1'b0;
        @(negedge clk);
        check_val("rst_mid_strb", strobes(), 0);
        check_val("rst_mid_state", int'(state), S_CENTER);
        do_reset();

        // Random play.
        rb = '0;
        for (int f = 0; f < 300; f++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(5) == 0) rb[i] = ~rb[i];
            if ($urandom_range(9) == 0) rb[4] = ~rb[4];
            run_frame(rb, ($urandom_range(39) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/paddle_ctl.md
Name: paddle_ctl

Overview:
- Sequences the two-player paddle position datapath: the up/down-with-speed, clamped position registers.
- Debounces the raw buttons on a per-frame timebase and resolves up/down conflicts per player.
- Issues one-cycle move strobes plus a step size that grows while a button is held.
- Runs the round state machine (center, wait-for-start, play, freeze-after-point). The datapath moves only in PLAY, and paddles are recentred between rounds.

Parameters:
- DEB_FRAMES, 3: consecutive equal frame samples required to accept a button level (1..15).
- ACCEL_FRAMES, 8: frames of continuous same-direction hold per +1 step increment (1..255).
- MAX_STEP, 4: step saturation value (1..15).
- FREEZE_FRAMES, 60: frames spent in FREEZE after a point (1..255).

Ports:
- clk  in  1  system clock, all logic on posedge
- rstn  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse, once per video frame
- btn_p1_up, btn_p1_dn, btn_p2_up, btn_p2_dn  in  1 each  raw asynchronous buttons, active-high
- btn_start  in  1  raw asynchronous start/pause button, active-high
- point  in  1  one-cycle pulse from ball logic: a point was scored
- p1_up, p1_dn, p2_up, p2_dn  out  1 each  one-cycle move strobes to the datapath
- p1_step, p2_step  out  4  pixels to move, valid when the matching strobe is high
- center  out  1  one-cycle pulse: load paddles to centre position
- playing  out  1  high while in PLAY
- state  out  2  current state encoding, for debug/overlay

Behaviour:
- Reset, sampled while rstn=0 on a clk edge:
  - all strobes, center and playing = 0; p1_step = p2_step = 1; state = CENTER.
  - Debouncers clear to "released"; hold counters = 0; freeze counter = 0.
- Input path:
  - Each raw button passes through a 2-flop synchroniser, then a debouncer.
  - The debounced level changes only on frame_tick, after DEB_FRAMES consecutive equal synchronised samples.
  - start_edge = rising edge of debounced start, one cycle wide.
- State machine, encodings CENTER=0, WAIT=1, PLAY=2, FREEZE=3:
  - CENTER: center=1 for exactly this cycle; next state WAIT.
  - WAIT: no strobes; start_edge -> PLAY.
  - PLAY: playing=1; start_edge -> WAIT (pause, no recentre); point -> FREEZE and load the freeze counter with FREEZE_FRAMES.
  - FREEZE: no strobes; decrement on frame_tick; at 0 -> CENTER. start_edge and point are ignored.
- Per-player move logic, evaluated only on frame_tick in PLAY:
  - Direction is up if up&!dn, down if dn&!up, none otherwise (both pressed = none).
  - Same non-none direction as the previous frame: hold_cnt += 1, saturating at 255. Otherwise hold_cnt = 0.
  - step = min(MAX_STEP, 1 + hold_cnt / ACCEL_FRAMES), computed with integer division.
  - Strobe and step are registered, asserted the cycle after frame_tick (latency 1), high for 1 cycle.
  - The step output holds its value between strobes.
- Simultaneous events:
  - point together with frame_tick in PLAY: point wins, no strobes that frame.
  - start_edge together with point in PLAY: point wins.
  - Leaving PLAY clears both hold counters.
- Reset mid-operation:
  - Any pending strobe is suppressed.
  - The first cycle after rstn returns high is CENTER, so center pulses.
- Player channels are independent; no cross-player arbitration.

Decomposition:
- Package paddle_ctl_pkg holds:
  - the state typedef (2-bit enum CENTER/WAIT/PLAY/FREEZE);
  - the direction typedef (NONE/UP/DN);
  - the STEP_W=4 and HOLD_W=8 constants.
- Sub-module btn_debounce: synchroniser plus frame-sampled counter with DEB_FRAMES parameter. It outputs the level and a rise pulse and is instantiated 5 times.

Test Plan:
- Reset then idle: center=1 in cycle 1 after rstn rises, state=1 thereafter. Hold btn_p1_up 10 frames: no p1_up strobe.
- Start held 3 frames -> state=2, playing=1. Hold p1_dn 20 frames: first p1_dn one cycle after frame_tick, step sequence 1 for hold_cnt 0..7, 2 for 8..15, 3 for 16..19; exactly one strobe per frame.
- In PLAY, press p2_up and p2_dn together for 5 frames -> zero p2 strobes and hold reset. Then p2_up alone gives step=1.
- Hold p1_up 40 frames (ACCEL_FRAMES=8) -> step saturates at 4 from hold_cnt 24 onward.
- Pulse point coincident with frame_tick while p1_up is held -> no strobe; state=3 for 60 frames, then center pulse, then state=1.
- Glitch: btn_p1_up high for 2 frames only (DEB_FRAMES=3) -> no strobe. Assert rstn=0 on a frame_tick cycle in PLAY -> no strobe next cycle, state=0.
